// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-size decode for the load/store sequencer.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ1  = 3'd1;
  localparam state_t ST_WAIT1 = 3'd2;
  localparam state_t ST_REQ2  = 3'd3;
  localparam state_t ST_WAIT2 = 3'd4;
  localparam state_t ST_RESP  = 3'd5;

  typedef struct packed {
    logic       legal;
    logic [3:0] mask;
  } lsu_size_t;

  // mask holds one bit per byte of the access, right-aligned
  function automatic lsu_size_t size_decode(input logic is_store, input logic [2:0] f3);
    lsu_size_t s;
    s.legal = 1'b1;
    s.mask  = 4'b0000;
    case (f3)
      F3_LB, F3_LBU: s.mask = 4'b0001;
      F3_LH, F3_LHU: s.mask = 4'b0011;
      F3_LW:         s.mask = 4'b1111;
      default:       s.legal = 1'b0;
    endcase
    if (is_store && f3[2]) s.legal = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane arithmetic: byte enables for both word accesses, shifted store data,
// and the shifted/extended load result.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [3:0]  size_mask,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [3:0]  be1,
  output logic [3:0]  be2,
  output logic        split,
  output logic [63:0] wd64,
  output logic [31:0] ld_data
);

  logic [7:0]  mask8;
  logic [63:0] sh;

  always_comb begin
    mask8 = {4'b0000, size_mask} << off;
    be1   = mask8[3:0];
    be2   = mask8[7:4];
    split = |be2;
    wd64  = {32'b0, wdata} << {off, 3'b000};
    sh    = {hi_word, lo_word} >> {off, 3'b000};
    case (funct3)
      F3_LB:   ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  ld_data = {24'b0, sh[7:0]};
      F3_LHU:  ld_data = {16'b0, sh[15:0]};
      default: ld_data = sh[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_unalign_seq.sv
// Load/store sequencer: one bus transaction per request, two when the access
// crosses a word boundary, with optional grant/response watchdog.
//
// state  | meaning
// IDLE   | waiting for start
// REQ1   | first access requested, waiting for gnt
// WAIT1  | first access granted, waiting for r_valid
// REQ2   | second (next word) access requested
// WAIT2  | second access granted, waiting for r_valid
// RESP   | done (and err if aborted) pulse
module lsu_unalign_seq
  import lsu_pkg::*;
#(
  parameter bit          ALLOW_SPLIT = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        data_req,
  input  logic        data_gnt,
  input  logic        data_r_valid,
  output logic [31:0] data_adr,
  output logic [3:0]  data_be,
  output logic [31:0] data_write,
  output logic        data_write_enable,
  input  logic [31:0] data_read,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam bit WD_EN = (TIMEOUT_CYC != 0);
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_EN ? WD_W'(TIMEOUT_CYC - 1) : '0;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [31:0] cur_addr;
  logic        cur_we;
  logic [2:0]  cur_f3;
  lsu_size_t   sz;
  logic [3:0]  be1, be2;
  logic        split;
  logic [63:0] wd64;
  logic [31:0] ld_data;
  logic        wd_tc;
  logic [29:0] word_q;

  // In IDLE the lane logic looks at the live request so the split decision is
  // available in the same cycle as start; afterwards it uses the captured copy.
  always_comb begin
    cur_addr = (state_q == ST_IDLE) ? addr   : addr_q;
    cur_we   = (state_q == ST_IDLE) ? we     : we_q;
    cur_f3   = (state_q == ST_IDLE) ? funct3 : f3_q;
    sz       = size_decode(cur_we, cur_f3);
  end

  lsu_lane_align u_lane (
    .off       (cur_addr[1:0]),
    .size_mask (sz.mask),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .lo_word   (lo_d),
    .hi_word   (hi_d),
    .be1       (be1),
    .be2       (be2),
    .split     (split),
    .wd64      (wd64),
    .ld_data   (ld_data)
  );

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (state_q == ST_WAIT1 && data_r_valid) lo_d = data_read;
    if (state_q == ST_WAIT2 && data_r_valid) hi_d = data_read;
  end

  assign wd_tc = WD_EN && (wd_q == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wd_d    = (wd_q != '0) ? wd_q - WD_W'(1) : wd_q;
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (start) begin
          addr_d  = addr;
          we_d    = we;
          f3_d    = funct3;
          wdata_d = wdata;
          wd_d    = WD_LOAD;
          if (!sz.legal || (split && !ALLOW_SPLIT)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ1;
          end
        end
      end
      ST_REQ1, ST_REQ2: begin
        if (data_gnt) begin
          state_d = (state_q == ST_REQ1) ? ST_WAIT1 : ST_WAIT2;
          wd_d    = WD_LOAD;
        end else if (wd_tc) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      ST_WAIT1, ST_WAIT2: begin
        if (data_r_valid) begin
          if (state_q == ST_WAIT1 && split) begin
            state_d = ST_REQ2;
            wd_d    = WD_LOAD;
          end else begin
            state_d = ST_RESP;
            if (!we_q) rdata_d = ld_data;
          end
        end else if (wd_tc) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign word_q = addr_q[31:2];

  always_comb begin
    data_req          = 1'b0;
    data_adr          = '0;
    data_be           = '0;
    data_write        = '0;
    data_write_enable = 1'b0;
    if (state_q == ST_REQ1) begin
      data_req          = 1'b1;
      data_adr          = {word_q, 2'b00};
      data_be           = be1;
      data_write        = wd64[31:0];
      data_write_enable = we_q;
    end else if (state_q == ST_REQ2) begin
      data_req          = 1'b1;
      data_adr          = {word_q + 30'd1, 2'b00};
      data_be           = be2;
      data_write        = wd64[63:32];
      data_write_enable = we_q;
    end
  end

  assign rdata = rdata_q;
  assign done  = (state_q == ST_RESP);
  assign err   = err_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lsu_unalign_seq.sv
// Directed bench for lsu_unalign_seq: vector table on a zero-wait bus model plus
// hand sequences for busy-ignore, watchdog, blocked split and mid-access reset.
module tb_lsu_unalign_seq;
  import lsu_pkg::*;

  logic        CLK, RES;
  logic        start, start_ns, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        data_req, data_gnt, data_r_valid, data_write_enable;
  logic [31:0] data_adr, data_write, data_read, rdata;
  logic [3:0]  data_be;
  logic        done, err, busy;

  logic        req_ns, we_en_ns, done_ns, err_ns, busy_ns;
  logic [31:0] adr_ns, write_ns, rdata_ns;
  logic [3:0]  be_ns;
  logic        zero_b;
  logic [31:0] zero_w;

  logic        gnt_en, rv_en, pend_q;
  logic [31:0] rd_q;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] dat;
    logic        we;
  } acc_t;
  acc_t acc_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_tests, n_fail;

  lsu_unalign_seq #(.ALLOW_SPLIT(1'b1), .TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .RES(RES), .start(start), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .data_req(data_req), .data_gnt(data_gnt),
    .data_r_valid(data_r_valid), .data_adr(data_adr), .data_be(data_be),
    .data_write(data_write), .data_write_enable(data_write_enable),
    .data_read(data_read), .rdata(rdata), .done(done), .err(err), .busy(busy)
  );

  lsu_unalign_seq #(.ALLOW_SPLIT(1'b0), .TIMEOUT_CYC(0)) dut_ns (
    .CLK(CLK), .RES(RES), .start(start_ns), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .data_req(req_ns), .data_gnt(zero_b),
    .data_r_valid(zero_b), .data_adr(adr_ns), .data_be(be_ns),
    .data_write(write_ns), .data_write_enable(we_en_ns),
    .data_read(zero_w), .rdata(rdata_ns), .done(done_ns), .err(err_ns), .busy(busy_ns)
  );

  assign zero_b = 1'b0;
  assign zero_w = 32'h0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // zero-wait responder: grant in the request cycle, response the next cycle
  assign data_gnt     = data_req && gnt_en;
  assign data_r_valid = pend_q && rv_en;
  assign data_read    = rd_q;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge CLK or negedge RES) begin
    if (!RES) begin
      pend_q <= 1'b0;
      rd_q   <= 32'h0;
    end else begin
      pend_q <= data_req && data_gnt;
      if (data_req && data_gnt) begin
        rd_q <= mem_rd(data_adr);
        acc_q.push_back('{data_adr, data_be, data_write, data_write_enable});
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic e,
                         output logic [31:0] rd, output logic dn_after, output logic bz_after);
    @(negedge CLK);
    we = w; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(negedge CLK);
    start = 1'b0; we = ~w; funct3 = 3'b011; addr = ~a; wdata = ~wd;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    e  = err;
    rd = rdata;
    @(negedge CLK);
    dn_after = done;
    bz_after = busy;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, m0, m1, exp_rd;
    int          exp_lat;
    logic        exp_err;
    int          exp_n;
    logic [31:0] adr0; logic [3:0] be0; logic [31:0] dat0;
    logic [31:0] adr1; logic [3:0] be1; logic [31:0] dat1;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, n;
    logic e, dn_after, bz_after, seen;
    logic [31:0] rd, wa;

    n_tests = 0; n_fail = 0;
    vecs[0]  = '{"lw_split",  1'b0, F3_LW,  32'h0000_1002, 32'h0, 32'h4433_2211, 32'h8877_6655, 32'h6655_4433, 5, 1'b0, 2, 32'h1000, 4'b1100, 32'h0, 32'h1004, 4'b0011, 32'h0};
    vecs[1]  = '{"lh_split",  1'b0, F3_LH,  32'h0000_1003, 32'h0, 32'h4433_2211, 32'h0000_00AA, 32'hFFFF_AA44, 5, 1'b0, 2, 32'h1000, 4'b1000, 32'h0, 32'h1004, 4'b0001, 32'h0};
    vecs[2]  = '{"lhu_split", 1'b0, F3_LHU, 32'h0000_1003, 32'h0, 32'h4433_2211, 32'h0000_00AA, 32'h0000_AA44, 5, 1'b0, 2, 32'h1000, 4'b1000, 32'h0, 32'h1004, 4'b0001, 32'h0};
    vecs[3]  = '{"sw_split",  1'b1, F3_SW,  32'h0000_2001, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0000_AA44, 5, 1'b0, 2, 32'h2000, 4'b1110, 32'hADBE_EF00, 32'h2004, 4'b0001, 32'h0000_00DE};
    vecs[4]  = '{"sb",        1'b1, F3_SB,  32'h0000_3002, 32'h0000_005A, 32'h0, 32'h0, 32'h0000_AA44, 3, 1'b0, 1, 32'h3000, 4'b0100, 32'h005A_0000, 32'h0, 4'b0, 32'h0};
    vecs[5]  = '{"lw_align",  1'b0, F3_LW,  32'h0000_4000, 32'h0, 32'h1234_5678, 32'h0, 32'h1234_5678, 3, 1'b0, 1, 32'h4000, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0};
    vecs[6]  = '{"lb_neg",    1'b0, F3_LB,  32'h0000_4003, 32'h0, 32'h8034_5678, 32'h0, 32'hFFFF_FF80, 3, 1'b0, 1, 32'h4000, 4'b1000, 32'h0, 32'h0, 4'b0, 32'h0};
    vecs[7]  = '{"lbu",       1'b0, F3_LBU, 32'h0000_4001, 32'h0, 32'h1234_F678, 32'h0, 32'h0000_00F6, 3, 1'b0, 1, 32'h4000, 4'b0010, 32'h0, 32'h0, 4'b0, 32'h0};
    vecs[8]  = '{"lw_wrap",   1'b0, F3_LW,  32'hFFFF_FFFE, 32'h0, 32'hBBAA_9988, 32'h7766_CCDD, 32'hCCDD_BBAA, 5, 1'b0, 2, 32'hFFFF_FFFC, 4'b1100, 32'h0, 32'h0000_0000, 4'b0011, 32'h0};
    vecs[9]  = '{"ld_f3_011", 1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 32'hCCDD_BBAA, 1, 1'b1, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0};
    vecs[10] = '{"st_f3_100", 1'b1, 3'b100, 32'h0000_2000, 32'h1111_1111, 32'h0, 32'h0, 32'hCCDD_BBAA, 1, 1'b1, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0};
    vecs[11] = '{"sh",        1'b1, F3_SH,  32'h0000_5002, 32'h0000_BEEF, 32'h0, 32'h0, 32'hCCDD_BBAA, 3, 1'b0, 1, 32'h5000, 4'b1100, 32'hBEEF_0000, 32'h0, 4'b0, 32'h0};

    RES = 1'b0; start = 1'b0; start_ns = 1'b0; we = 1'b0; funct3 = 3'b0;
    addr = 32'h0; wdata = 32'h0; gnt_en = 1'b1; rv_en = 1'b1;
    #12;
    chk("rst_req",   {31'b0, data_req}, 32'h0);
    chk("rst_busy",  {31'b0, busy}, 32'h0);
    chk("rst_done",  {31'b0, done}, 32'h0);
    chk("rst_err",   {31'b0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_adr",   data_adr, 32'h0);
    chk("rst_be",    {28'b0, data_be}, 32'h0);
    chk("rst_wdata", data_write, 32'h0);
    chk("rst_wen",   {31'b0, data_write_enable}, 32'h0);
    @(negedge CLK);
    RES = 1'b1;

    for (int i = 0; i < 12; i++) begin
      wa = {vecs[i].addr[31:2], 2'b00};
      mem[wa] = vecs[i].m0;
      mem[wa + 32'd4] = vecs[i].m1;
      acc_q.delete();
      run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, e, rd, dn_after, bz_after);
      chk({vecs[i].name, ".lat"},   32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, ".err"},   {31'b0, e}, {31'b0, vecs[i].exp_err});
      chk({vecs[i].name, ".rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, ".pulse"}, {30'b0, dn_after, bz_after}, 32'h0);
      chk({vecs[i].name, ".nacc"},  32'(acc_q.size()), 32'(vecs[i].exp_n));
      if (vecs[i].exp_n >= 1 && acc_q.size() >= 1) begin
        chk({vecs[i].name, ".adr0"}, acc_q[0].adr, vecs[i].adr0);
        chk({vecs[i].name, ".be0"},  {28'b0, acc_q[0].be}, {28'b0, vecs[i].be0});
        chk({vecs[i].name, ".dat0"}, acc_q[0].dat, vecs[i].dat0);
        chk({vecs[i].name, ".we0"},  {31'b0, acc_q[0].we}, {31'b0, vecs[i].we});
      end
      if (vecs[i].exp_n >= 2 && acc_q.size() >= 2) begin
        chk({vecs[i].name, ".adr1"}, acc_q[1].adr, vecs[i].adr1);
        chk({vecs[i].name, ".be1"},  {28'b0, acc_q[1].be}, {28'b0, vecs[i].be1});
        chk({vecs[i].name, ".dat1"}, acc_q[1].dat, vecs[i].dat1);
        chk({vecs[i].name, ".we1"},  {31'b0, acc_q[1].we}, {31'b0, vecs[i].we});
      end
    end

    // start while busy must be ignored; bus outputs hold while gnt is withheld
    mem[32'h4000] = 32'hCAFE_F00D;
    acc_q.delete();
    gnt_en = 1'b0;
    @(negedge CLK);
    we = 1'b0; funct3 = F3_LW; addr = 32'h4000; wdata = 32'h0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    chk("hold_req", {31'b0, data_req}, 32'h1);
    chk("hold_adr", data_adr, 32'h4000);
    we = 1'b1; funct3 = F3_SW; addr = 32'h6000; wdata = 32'h9999_9999; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("hold_adr2", data_adr, 32'h4000);
    chk("hold_be",   {28'b0, data_be}, 32'hF);
    gnt_en = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("busy_done",  {31'b0, done}, 32'h1);
    chk("busy_rdata", rdata, 32'hCAFE_F00D);
    repeat (4) @(negedge CLK);
    chk("busy_idle", {31'b0, busy}, 32'h0);
    chk("busy_nacc", 32'(acc_q.size()), 32'h1);

    // watchdog: grant never arrives
    acc_q.delete();
    gnt_en = 1'b0;
    run_txn(1'b0, F3_LW, 32'h4000, 32'h0, lat, e, rd, dn_after, bz_after);
    chk("wd_lat",   32'(lat), 32'd9);
    chk("wd_err",   {31'b0, e}, 32'h1);
    chk("wd_rdata", rd, 32'hCAFE_F00D);
    chk("wd_nacc",  32'(acc_q.size()), 32'h0);
    chk("wd_pulse", {30'b0, dn_after, bz_after}, 32'h0);
    gnt_en = 1'b1;

    // ALLOW_SPLIT=0 instance rejects a word-crossing access without bus activity
    seen = 1'b0;
    @(negedge CLK);
    we = 1'b0; funct3 = F3_LW; addr = 32'h1001; start_ns = 1'b1;
    @(negedge CLK);
    start_ns = 1'b0;
    seen = seen | req_ns;
    chk("ns_done", {31'b0, done_ns}, 32'h1);
    chk("ns_err",  {31'b0, err_ns}, 32'h1);
    @(negedge CLK);
    seen = seen | req_ns;
    chk("ns_noreq", {31'b0, seen}, 32'h0);
    chk("ns_idle",  {30'b0, done_ns, busy_ns}, 32'h0);

    // reset during WAIT2 aborts without a done
    mem[32'h1000] = 32'h4433_2211;
    mem[32'h1004] = 32'h8877_6655;
    acc_q.delete();
    @(negedge CLK);
    we = 1'b0; funct3 = F3_LW; addr = 32'h1002; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (acc_q.size() < 2 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    rv_en = 1'b0;
    chk("w2_nacc", 32'(acc_q.size()), 32'h2);
    chk("w2_busy_pre", {31'b0, busy}, 32'h1);
    #2 RES = 1'b0;
    #1;
    chk("w2_rst_req",  {31'b0, data_req}, 32'h0);
    chk("w2_rst_busy", {31'b0, busy}, 32'h0);
    @(negedge CLK);
    RES = 1'b1;
    rv_en = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      seen = seen | done;
    end
    chk("w2_no_done", {31'b0, seen}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
